// File: rtl/calc_seq_pkg.sv
// Shared encodings for the calculator sequencer: FSM states, op codes and
// the phase values the top-level display mux keys off.
package calc_seq_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_RUN  = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    localparam logic [1:0] PHASE_A    = 2'd0;
    localparam logic [1:0] PHASE_B    = 2'd1;
    localparam logic [1:0] PHASE_OP   = 2'd2;
    localparam logic [1:0] PHASE_EXEC = 2'd3;

    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            S_A:     return PHASE_A;
            S_B:     return PHASE_B;
            S_OP:    return PHASE_OP;
            default: return PHASE_EXEC;
        endcase
    endfunction

endpackage

// File: rtl/calc_seq_shift_mul.sv
// Iterative W x W shift-add multiplier, LSB-first over i_b, N steps per
// product; o_done and o_product are valid together on the final step.
module shift_mul #(
    parameter int W = 8,
    parameter int N = W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*W-1:0] o_product
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic           r_busy;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] w_acc_nx;

    assign w_acc_nx  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_cnt == LAST);
    assign o_product = w_acc_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{W{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_nx;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key.sv
// Push-button edge detector: two-flop synchronizer plus history flop,
// pulses o_push for one cycle when the active-low button is released.
module key (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_push
);
    // Flops hold the pressed level so their reset value of 0 means idle.
    logic r_k1, r_k2, r_k3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k1 <= 1'b0;
            r_k2 <= 1'b0;
            r_k3 <= 1'b0;
        end else begin
            r_k1 <= ~i_key_n;
            r_k2 <= r_k1;
            r_k3 <= r_k2;
        end
    end

    assign o_push = r_k3 & ~r_k2;

endmodule

// File: rtl/calc_seq.sv
// Calculator operation sequencer: commits A, B and op from switches on key
// releases, computes add/sub in one cycle or multiply via shift_mul.
module calc_seq
    import calc_seq_pkg::*;
#(
    parameter int W          = 8,
    parameter int MUL_CYCLES = W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_next,
    input  logic           key_clr,
    input  logic [15:0]    sw,
    output logic [W-1:0]   a_val,
    output logic [W-1:0]   b_val,
    output logic [2*W-1:0] result,
    output logic           carry,
    output logic           err,
    output logic           busy,
    output logic           done,
    output logic [1:0]     phase,
    output logic [2:0]     dbg_state
);
    state_t         r_state, w_state_nx;
    logic [W-1:0]   r_a, r_b, w_a_nx, w_b_nx;
    logic [2*W-1:0] r_result, w_result_nx;
    logic           r_carry, r_err, r_busy, r_done;
    logic           w_carry_nx, w_err_nx, w_busy_nx, w_done_nx;
    logic           r_clr_s1, r_clr_s2;
    logic           w_push, w_clr, w_soft_rst;
    logic           w_mul_start, w_mul_done, w_unused_mul_busy;
    logic [2*W-1:0] w_mul_product;
    logic [W:0]     w_sum;
    logic           w_unused_sw;

    assign w_unused_sw = ^sw[15:10];

    key u_key (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_next),
        .o_push  (w_push)
    );

    // The clear synchronizer only answers to rst so a held key_clr keeps clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_s1 <= 1'b0;
            r_clr_s2 <= 1'b0;
        end else begin
            r_clr_s1 <= ~key_clr;
            r_clr_s2 <= r_clr_s1;
        end
    end

    assign w_clr      = r_clr_s2;
    assign w_soft_rst = rst | w_clr;

    shift_mul #(.W(W), .N(MUL_CYCLES)) u_mul (
        .clk       (clk),
        .rst       (w_soft_rst),
        .i_start   (w_mul_start),
        .i_a       (r_a),
        .i_b       (r_b),
        .o_busy    (w_unused_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    always_comb begin
        w_state_nx  = r_state;
        w_a_nx      = r_a;
        w_b_nx      = r_b;
        w_result_nx = r_result;
        w_carry_nx  = r_carry;
        w_err_nx    = r_err;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_mul_start = 1'b0;
        case (r_state)
            S_A: if (w_push) begin
                w_a_nx     = sw[W-1:0];
                w_state_nx = S_B;
            end
            S_B: if (w_push) begin
                w_b_nx     = sw[W-1:0];
                w_state_nx = S_OP;
            end
            S_OP: if (w_push) begin
                case (sw[9:8])
                    OP_ADD: begin
                        w_result_nx = {{(W-1){1'b0}}, w_sum};
                        w_carry_nx  = w_sum[W];
                        w_err_nx    = 1'b0;
                        w_done_nx   = 1'b1;
                        w_state_nx  = S_SHOW;
                    end
                    OP_SUB: begin
                        w_result_nx = {{W{1'b0}}, r_a - r_b};
                        w_carry_nx  = (r_a < r_b);
                        w_err_nx    = 1'b0;
                        w_done_nx   = 1'b1;
                        w_state_nx  = S_SHOW;
                    end
                    OP_MUL: begin
                        w_mul_start = 1'b1;
                        w_busy_nx   = 1'b1;
                        w_state_nx  = S_RUN;
                    end
                    OP_BAD: begin
                        w_result_nx = '0;
                        w_carry_nx  = 1'b0;
                        w_err_nx    = 1'b1;
                        w_done_nx   = 1'b1;
                        w_state_nx  = S_SHOW;
                    end
                endcase
            end
            // Pushes are deliberately ignored here; the multiplier owns the cycle count.
            S_RUN: if (w_mul_done) begin
                w_result_nx = w_mul_product;
                w_carry_nx  = 1'b0;
                w_err_nx    = 1'b0;
                w_busy_nx   = 1'b0;
                w_done_nx   = 1'b1;
                w_state_nx  = S_SHOW;
            end
            S_SHOW: if (w_push) begin
                w_state_nx = S_A;
            end
            default: w_state_nx = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_soft_rst) begin
            r_state  <= S_A;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_a      <= w_a_nx;
            r_b      <= w_b_nx;
            r_result <= w_result_nx;
            r_carry  <= w_carry_nx;
            r_err    <= w_err_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

    assign a_val     = r_a;
    assign b_val     = r_b;
    assign result    = r_result;
    assign carry     = r_carry;
    assign err       = r_err;
    assign busy      = r_busy;
    assign done      = r_done;
    assign phase     = phase_of(r_state);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq: table of calculations plus hand-written
// sequences for pushes during multiply, S_SHOW hold, and rst/clr aborts.
module tb_calc_seq;
    import calc_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        key_next;
    logic        key_clr;
    logic [15:0] sw;
    logic [7:0]  a_val, b_val;
    logic [15:0] result;
    logic        carry, err, busy, done;
    logic [1:0]  phase;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        logic [15:0] exp_res;
        logic        exp_c;
        logic        exp_e;
    } vec_t;

    vec_t vecs[10];

    calc_seq dut (
        .clk       (clk),
        .rst       (rst),
        .key_next  (key_next),
        .key_clr   (key_clr),
        .sw        (sw),
        .a_val     (a_val),
        .b_val     (b_val),
        .result    (result),
        .carry     (carry),
        .err       (err),
        .busy      (busy),
        .done      (done),
        .phase     (phase),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver: press and release; returns one negedge after the FSM consumed the push
    task automatic press();
        key_next = 1'b0;
        repeat (3) @(negedge clk);
        key_next = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic enter_operands(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        sw = {6'b0, 2'b11, a};
        press();
        chk("phase_after_a", 32'(phase), 32'(PHASE_B));
        chk("a_val", 32'(a_val), 32'(a));
        sw = {6'b0, 2'b01, b};
        press();
        chk("phase_after_b", 32'(phase), 32'(PHASE_OP));
        chk("b_val", 32'(b_val), 32'(b));
        sw = {6'($urandom_range(0, 63)), op, 8'($urandom_range(0, 255))};
        press();
    endtask

    task automatic wait_done(output int busy_cycles, output bit got_done);
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit ret);
        int busy_cycles;
        bit got_done;
        enter_operands(v.a, v.b, v.op);
        wait_done(busy_cycles, got_done);
        chk("done_seen", 32'(got_done), 32'd1);
        chk("busy_cycles", 32'(busy_cycles), (v.op == OP_MUL) ? 32'd8 : 32'd0);
        chk("result", 32'(result), 32'(v.exp_res));
        chk("carry", 32'(carry), 32'(v.exp_c));
        chk("err", 32'(err), 32'(v.exp_e));
        chk("phase_show", 32'(phase), 32'(PHASE_EXEC));
        chk("state_show", 32'(dbg_state), 32'(S_SHOW));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("result_held", 32'(result), 32'(v.exp_res));
        if (ret) begin
            press();
            chk("phase_back_to_a", 32'(phase), 32'(PHASE_A));
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_a_val"}, 32'(a_val), 32'd0);
        chk({tag, "_b_val"}, 32'(b_val), 32'd0);
        chk({tag, "_flags"}, {28'd0, carry, err, busy, done}, 32'd0);
        chk({tag, "_phase"}, 32'(phase), 32'(PHASE_A));
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int n;
        int busy_cycles;
        bit got_done;

        vecs[0] = '{8'hFF, 8'h01, OP_ADD, 16'h0100, 1'b1, 1'b0};
        vecs[1] = '{8'h05, 8'h07, OP_SUB, 16'h00FE, 1'b1, 1'b0};
        vecs[2] = '{8'h07, 8'h05, OP_SUB, 16'h0002, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, OP_MUL, 16'hFE01, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 8'h37, OP_MUL, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, OP_ADD, 16'h01FE, 1'b1, 1'b0};
        vecs[6] = '{8'hA5, 8'h3C, OP_BAD, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{8'h12, 8'h34, OP_MUL, 16'h03A8, 1'b0, 1'b0};
        vecs[8] = '{8'h80, 8'h80, OP_ADD, 16'h0100, 1'b1, 1'b0};
        vecs[9] = '{8'h00, 8'h01, OP_SUB, 16'h00FF, 1'b1, 1'b0};

        rst      = 1'b1;
        key_next = 1'b1;
        key_clr  = 1'b1;
        sw       = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_cleared("reset");
        chk("reset_state", 32'(dbg_state), 32'(S_A));

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], 1'b1);
        end

        // extra push in the middle of a multiply is dropped
        enter_operands(8'hFF, 8'hFF, OP_MUL);
        chk("run_entered", 32'(dbg_state), 32'(S_RUN));
        press();
        chk("run_still_busy", 32'(busy), 32'd1);
        wait_done(busy_cycles, got_done);
        chk("run_push_done", 32'(got_done), 32'd1);
        chk("run_push_result", 32'(result), 32'hFE01);
        @(negedge clk);
        chk("run_push_state", 32'(dbg_state), 32'(S_SHOW));
        press();
        chk("run_push_back_a", 32'(phase), 32'(PHASE_A));

        // illegal op, then switches wiggled while showing
        run_vec(vecs[6], 1'b0);
        for (int i = 0; i < 5; i++) begin
            sw = 16'($urandom_range(0, 65535));
            @(negedge clk);
        end
        chk("hold_result", 32'(result), 32'h0);
        chk("hold_err", 32'(err), 32'd1);
        chk("hold_a_b", {16'd0, a_val, b_val}, 32'hA53C);
        chk("hold_phase", 32'(phase), 32'(PHASE_EXEC));
        press();
        chk("hold_back_a", 32'(phase), 32'(PHASE_A));

        // rst during S_RUN
        enter_operands(8'hFF, 8'hFF, OP_MUL);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_cleared("rst_abort");
        count_done(14, n);
        chk("rst_abort_no_done", 32'(n), 32'd0);
        chk("rst_abort_phase", 32'(phase), 32'(PHASE_A));
        run_vec(vecs[3], 1'b1);

        // clr held low during S_RUN
        enter_operands(8'hFF, 8'hFF, OP_MUL);
        repeat (3) @(negedge clk);
        key_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_cleared("clr_abort");
        key_clr = 1'b1;
        count_done(14, n);
        chk("clr_abort_no_done", 32'(n), 32'd0);
        chk("clr_abort_phase", 32'(phase), 32'(PHASE_A));
        run_vec(vecs[7], 1'b1);
        run_vec(vecs[0], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_seq.md
Name: calc_seq

Overview:
- Operation sequencer for the board-level switch/key/7-segment calculator datapath.
- The user enters operand A, then operand B, then an operation code, all from switches. Each entry is committed with one key press.
- The block computes add, subtract or multiply. Add and subtract take one cycle; multiply uses an iterative shift-add over 8 cycles.
- The result is held for display on the hex digits, with a carry/borrow LED and a phase indicator for the top-level display muxing.

Parameters:
- W, 8, operand width. The result is 2*W bits wide.
- MUL_CYCLES, W, number of shift-add iterations in S_RUN. Must equal W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_next  in  1  raw push-button, active-low. It is edge-detected internally and commits the current entry.
- key_clr  in  1  raw push-button, active-low, level-sensitive. It is synchronized internally and acts as a soft clear.
- sw  in  16  switches. sw[W-1:0] is the operand value; sw[9:8] is the operation code.
- a_val  out  W  latched operand A.
- b_val  out  W  latched operand B.
- result  out  2*W  last computed result.
- carry  out  1  add carry-out, or subtract borrow.
- err  out  1  an illegal operation code was selected.
- busy  out  1  high while in S_RUN.
- done  out  1  one-cycle pulse when a result is written.
- phase  out  2  current entry state: 0=S_A, 1=S_B, 2=S_OP, 3=S_RUN or S_SHOW.

Behaviour:
- Reset: on rst=1 at a clock edge, every output register is 0, state is S_A, the multiply counter and partial product are 0, and edge-detector flops are 0.
- Priority at each edge: rst, then clr (synchronized key_clr low), then push.
- clr has the same effect as rst, except the key synchronizer flops keep running.
- push is the one-cycle pulse from the existing key edge-detector. It fires on the 0-to-1 transition of the twice-registered key_next (the button release).
- All timing below is measured from the cycle where push=1.
- S_A + push: a_val<=sw[7:0], next state S_B.
- S_B + push: b_val<=sw[7:0], next state S_OP.
- S_OP + push: op<=sw[9:8], then by code:
  - 00 add: result<={7'b0, A+B (9-bit)}, carry<=sum[8], err<=0, done<=1, next state S_SHOW.
  - 01 sub: result[7:0]<=A-B mod 256, result[15:8]<=0, carry<=(A<B), err<=0, done<=1, next state S_SHOW.
  - 10 mul: clear partial product and counter, busy<=1, next state S_RUN.
  - 11: result<=0, carry<=0, err<=1, done<=1, next state S_SHOW.
- S_RUN: one shift-add step per cycle, LSB-first over b_val. The counter runs 0 to MUL_CYCLES-1.
  - On the step where counter=MUL_CYCLES-1: result<=full 16-bit product, carry<=0, err<=0, busy<=0, done<=1, next state S_SHOW.
  - The result is therefore visible MUL_CYCLES+1 edges after the push edge.
- S_RUN ignores push. A press during S_RUN is dropped, not queued.
- S_SHOW + push: next state S_A. result, carry and err are held until the next compute; a_val and b_val are held until overwritten.
- done is high for exactly one cycle per computation and is 0 everywhere else.
- result only changes on a done cycle, or on rst/clr.
- Reset or clr during S_RUN: multiply aborted, no done pulse, all state cleared as for reset.
- Operand wrap: no saturation. Add 0xFF+0xFF = 0x01FE with carry=1.
- sw changing while not committing has no effect on any output.

Decomposition:
- Shared package:
  - state encoding: S_A=0, S_B=1, S_OP=2, S_RUN=3, S_SHOW=4 (3-bit localparams);
  - op-code localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_BAD=2'b11;
  - PHASE_* values.
- Sub-module: reuse the existing `key` edge detector for key_next.
- One natural new sub-module, `shift_mul`: a sequential W×W shift-add multiplier with start/busy/done ports, instantiated once.
- The key_clr synchronizer stays inline.

Test Plan:
- Add with carry: enter A=0xFF, B=0x01, op=00 → done 1 cycle after the third push; result=0x0100, carry=1, err=0; phase goes 0→1→2→3.
- Sub with borrow: enter A=0x05, B=0x07, op=01 → result=0x00FE, carry=1. Then A=0x07, B=0x05 → result=0x0002, carry=0.
- Multiply: enter A=0xFF, B=0xFF, op=10 → busy=1 for exactly 8 cycles, then done; result=0xFE01, carry=0. Also A=0x00 → result=0x0000.
- Press during S_RUN: issue an extra push 3 cycles into a multiply → result still 0xFE01, state S_SHOW. One further push returns to S_A.
- Illegal op and the S_SHOW hold: op=11 → err=1, result=0. sw toggled in S_SHOW → outputs unchanged.
- Reset and clr mid-operation: assert rst, or hold key_clr low, at cycle 4 of S_RUN → no done pulse; all outputs 0, phase=0. The next full sequence computes correctly.
